div32x32_iter: RTL and testbench

Iterative 32/32 unsigned restoring divider. It is the inverse-operation companion to the team's 32x32 iterative multiplier and uses the same start/busy handshake. It produces the quotient and remainder over several cycles using a shift/subtract datapath and a small control FSM. It sits beside the multiplier in the arithmetic unit.

---
 rtl/div32x32_iter_if.sv | 30 +++
 rtl/div32x32_iter.sv | 152 +++++++++++++++
 tb/tb_div32x32_iter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/div32x32_iter_if.sv
// rtl/div32x32_iter_if.sv - start/busy handshake and operand/result bundle for div32x32_iter
// Optional signed_op member is present when DIV32X32_SIGNED_EN is defined.
interface div32x32_iter_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
`ifdef DIV32X32_SIGNED_EN
  logic        signed_op;
`endif
  logic        busy;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  modport master (
`ifdef DIV32X32_SIGNED_EN
    output signed_op,
`endif
    output start, a, b,
    input  busy, quotient, remainder, div_by_zero
  );

  modport slave (
`ifdef DIV32X32_SIGNED_EN
    input  signed_op,
`endif
    input  start, a, b,
    output busy, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div32x32_iter.sv
// rtl/div32x32_iter.sv - iterative 32/32 restoring divider, RADIX_BITS quotient bits per cycle
// Signed operation (signed_op, FIXUP state) is enabled by defining DIV32X32_SIGNED_EN.
module div32x32_iter #(
  parameter int RADIX_BITS = 1
) (
  input  logic           clk,
  input  logic           reset,
  div32x32_iter_if.slave bus
);
  localparam int         N    = 32 / RADIX_BITS;
  localparam logic [4:0] LAST = 5'(N - 1);

`ifdef DIV32X32_SIGNED_EN
  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
`endif

  state_t      state, state_nxt;
  logic [4:0]  count;
  logic [32:0] rem_q;
  logic [31:0] dvd_q;
  logic [31:0] dvs_q;
  logic [31:0] a_q;
  logic        dz_q;
  logic [31:0] quotient_q;
  logic [31:0] remainder_q;
  logic        div_by_zero_q;
  logic [31:0] a_mag, b_mag;
  logic [64:0] step1, step2;
  logic [32:0] rem_nxt;
  logic [31:0] dvd_nxt;
`ifdef DIV32X32_SIGNED_EN
  logic        signed_q;
  logic        neg_quo_q;
  logic        neg_rem_q;
`endif

  // One restoring step: returns {new partial remainder, dividend shifted with quotient bit in LSB}.
  function automatic logic [64:0] div_step(input logic [32:0] rem, input logic [31:0] dq,
                                           input logic [31:0] d);
    logic [33:0] sh;
    logic [34:0] diff;
    sh   = {rem, dq[31]};
    diff = {1'b0, sh} - {3'b000, d};
    if (diff[34:33] == 2'b00) return {diff[32:0], dq[30:0], 1'b1};
    else                      return {sh[32:0], dq[30:0], 1'b0};
  endfunction

  always_comb begin
    step1 = div_step(rem_q, dvd_q, dvs_q);
    step2 = div_step(step1[64:32], step1[31:0], dvs_q);
    {rem_nxt, dvd_nxt} = (RADIX_BITS == 2) ? step2 : step1;
  end

  always_comb begin
    a_mag = bus.a;
    b_mag = bus.b;
`ifdef DIV32X32_SIGNED_EN
    if (bus.signed_op && bus.a[31]) a_mag = -bus.a;
    if (bus.signed_op && bus.b[31]) b_mag = -bus.b;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = (bus.b == 32'd0) ? DONE : CALC;
      CALC: if (count == 5'd0) begin
`ifdef DIV32X32_SIGNED_EN
        state_nxt = signed_q ? FIXUP : DONE;
`else
        state_nxt = DONE;
`endif
      end
`ifdef DIV32X32_SIGNED_EN
      FIXUP: state_nxt = DONE;
`endif
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count         <= 5'd0;
      rem_q         <= 33'd0;
      dvd_q         <= 32'd0;
      dvs_q         <= 32'd0;
      a_q           <= 32'd0;
      dz_q          <= 1'b0;
      quotient_q    <= 32'd0;
      remainder_q   <= 32'd0;
      div_by_zero_q <= 1'b0;
`ifdef DIV32X32_SIGNED_EN
      signed_q      <= 1'b0;
      neg_quo_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          a_q   <= bus.a;
          dvd_q <= a_mag;
          dvs_q <= b_mag;
          rem_q <= 33'd0;
          count <= LAST;
          dz_q  <= (bus.b == 32'd0);
`ifdef DIV32X32_SIGNED_EN
          signed_q  <= bus.signed_op;
          neg_quo_q <= bus.signed_op && (bus.a[31] ^ bus.b[31]);
          neg_rem_q <= bus.signed_op && bus.a[31];
`endif
        end
        CALC: begin
          rem_q <= rem_nxt;
          dvd_q <= dvd_nxt;
          count <= count - 5'd1;
        end
`ifdef DIV32X32_SIGNED_EN
        // Truncating division: quotient sign from operand signs, remainder follows the dividend.
        FIXUP: begin
          if (neg_quo_q) dvd_q <= -dvd_q;
          if (neg_rem_q) rem_q <= {1'b0, -rem_q[31:0]};
        end
`endif
        DONE: begin
          if (dz_q) begin
            quotient_q    <= 32'hFFFF_FFFF;
            remainder_q   <= a_q;
            div_by_zero_q <= 1'b1;
          end else begin
            quotient_q    <= dvd_q;
            remainder_q   <= rem_q[31:0];
            div_by_zero_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = div_by_zero_q;
endmodule

// File: tb/tb_div32x32_iter.sv
// tb/tb_div32x32_iter.sv - self-checking bench for div32x32_iter, radix-1 and radix-2 instances
module tb_div32x32_iter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  div32x32_iter_if if1 ();
  div32x32_iter_if if2 ();

  assign if1.start = start;
  assign if1.a     = a;
  assign if1.b     = b;
  assign if2.start = start;
  assign if2.a     = a;
  assign if2.b     = b;
`ifdef DIV32X32_SIGNED_EN
  assign if1.signed_op = 1'b0;
  assign if2.signed_op = 1'b0;
`endif

  div32x32_iter #(.RADIX_BITS(1)) u_r1 (.clk(clk), .reset(reset), .bus(if1));
  div32x32_iter #(.RADIX_BITS(2)) u_r2 (.clk(clk), .reset(reset), .bus(if2));

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  exp_t sb1[$];
  exp_t sb2[$];

  int   lat1 = 0, lat2 = 0;
  logic pb1 = 1'b0, pb2 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic complete(input int inst, input logic [31:0] q, input logic [31:0] r,
                          input logic dz, input int lat);
    exp_t e;
    if ((inst == 1 && sb1.size() == 0) || (inst == 2 && sb2.size() == 0)) begin
      checks++;
      failures++;
      $display("FAIL unexpected_done r%0d: got q=%h r=%h expected no completion", inst, q, r);
      return;
    end
    e = (inst == 1) ? sb1.pop_front() : sb2.pop_front();
    check($sformatf("r%0d_quotient", inst), q, e.q);
    check($sformatf("r%0d_remainder", inst), r, e.r);
    check($sformatf("r%0d_div_by_zero", inst), 32'(dz), 32'(e.dz));
    check($sformatf("r%0d_busy_cycles", inst), 32'(lat), 32'(e.lat));
  endtask

  always @(negedge clk) begin
    if (reset) begin
      lat1 = 0; lat2 = 0; pb1 = 1'b0; pb2 = 1'b0;
    end else begin
      if (if1.busy) lat1++;
      else if (pb1) begin
        complete(1, if1.quotient, if1.remainder, if1.div_by_zero, lat1);
        lat1 = 0;
      end
      pb1 = if1.busy;
      if (if2.busy) lat2++;
      else if (pb2) begin
        complete(2, if2.quotient, if2.remainder, if2.div_by_zero, lat2);
        lat2 = 0;
      end
      pb2 = if2.busy;
    end
  end

  task automatic push_exp(input logic [31:0] q, input logic [31:0] r, input logic dz);
    exp_t e;
    e.q = q; e.r = r; e.dz = dz;
    e.lat = dz ? 1 : 33;
    sb1.push_back(e);
    e.lat = dz ? 1 : 17;
    sb2.push_back(e);
  endtask

  task automatic issue(input logic [31:0] ia, input logic [31:0] ib);
    @(negedge clk);
    start = 1'b1; a = ia; b = ib;
    @(negedge clk);
    start = 1'b0;
    check("r1_busy_after_start", 32'(if1.busy), 32'd1);
    check("r2_busy_after_start", 32'(if2.busy), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((sb1.size() != 0 || sb2.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb1.size() != 0 || sb2.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL completion_timeout: got %0d/%0d pending expected 0", sb1.size(), sb2.size());
      sb1.delete();
      sb2.delete();
    end
  endtask

  task automatic check_outputs_clear(input string tag);
    check({tag, "_r1_busy"}, 32'(if1.busy), 32'd0);
    check({tag, "_r1_quotient"}, if1.quotient, 32'd0);
    check({tag, "_r1_remainder"}, if1.remainder, 32'd0);
    check({tag, "_r1_dz"}, 32'(if1.div_by_zero), 32'd0);
    check({tag, "_r2_busy"}, 32'(if2.busy), 32'd0);
    check({tag, "_r2_quotient"}, if2.quotient, 32'd0);
    check({tag, "_r2_remainder"}, if2.remainder, 32'd0);
    check({tag, "_r2_dz"}, 32'(if2.div_by_zero), 32'd0);
  endtask

  initial begin
    vec_t        vecs[12];
    logic [31:0] prev_q;
    logic [31:0] ra, rb;

    vecs[0]  = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1]  = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
    vecs[2]  = '{32'd5,          32'hFFFF_FFFF,  32'd0,          32'd5,          1'b0};
    vecs[3]  = '{32'd1234,       32'd0,          32'hFFFF_FFFF,  32'd1234,       1'b1};
    vecs[4]  = '{32'd9,          32'd3,          32'd3,          32'd0,          1'b0};
    vecs[5]  = '{32'hDEAD_BEEF,  32'h0000_1234,  32'h000C_3BA5,  32'h0000_076B,  1'b0};
    vecs[6]  = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
    vecs[7]  = '{32'd7,          32'd7,          32'd1,          32'd0,          1'b0};
    vecs[8]  = '{32'd6,          32'd7,          32'd0,          32'd6,          1'b0};
    vecs[9]  = '{32'h8000_0000,  32'd2,          32'h4000_0000,  32'd0,          1'b0};
    vecs[10] = '{32'hFFFF_FFFF,  32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b0};
    vecs[11] = '{32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0,          1'b1};

    #12;
    check_outputs_clear("reset");
    @(negedge clk);
    reset = 1'b0;

    prev_q = 32'd0;
    for (int i = 0; i < 12; i++) begin
      push_exp(vecs[i].q, vecs[i].r, vecs[i].dz);
      issue(vecs[i].a, vecs[i].b);
      check($sformatf("hold_r1_quotient_v%0d", i), if1.quotient, prev_q);
      check($sformatf("hold_r2_quotient_v%0d", i), if2.quotient, prev_q);
      wait_done(100);
      prev_q = vecs[i].q;
    end

    // start pulse and operand changes while busy must not disturb the running operation
    push_exp(32'd333, 32'd1, 1'b0);
    issue(32'd1000, 32'd3);
    repeat (4) @(negedge clk);
    start = 1'b1; a = 32'd8; b = 32'd2;
    @(negedge clk);
    start = 1'b0; a = 32'd77; b = 32'd11;
    wait_done(100);
    repeat (40) @(negedge clk);
    check("ignored_start_r1_idle", 32'(if1.busy), 32'd0);
    check("ignored_start_r2_idle", 32'(if2.busy), 32'd0);

    // asynchronous reset in the middle of CALC
    issue(32'd5000, 32'd7);
    repeat (9) @(negedge clk);
    #2;
    reset = 1'b1;
    pb1 = 1'b0; pb2 = 1'b0; lat1 = 0; lat2 = 0;
    #1;
    check_outputs_clear("midreset");
    @(negedge clk);
    reset = 1'b0;
    push_exp(32'd9, 32'd0, 1'b0);
    issue(32'd81, 32'd9);
    wait_done(100);

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 49) == 0) rb = 32'd0;
      if (rb == 32'd0) push_exp(32'hFFFF_FFFF, ra, 1'b1);
      else             push_exp(ra / rb, ra % rb, 1'b0);
      issue(ra, rb);
      wait_done(100);
    end

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
